// File: rtl/count_chk_pkg.sv
// Shared definitions for the counter sequence checker: FSM encoding and
// default parameter values.
package count_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_LOCK_LEN = 3;
    localparam int DEF_CNT_W    = 8;

endpackage

// File: rtl/seq_cmp.sv
// Combinational good-sample test: q must be prev+1 (modulo) and qbar its
// exact bitwise complement; also flags the max-to-zero step.
module seq_cmp
    import count_chk_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_prev,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_qbar,
    output logic             o_good,
    output logic             o_wrap
);

    logic [WIDTH-1:0] w_expected;

    assign w_expected = i_prev + WIDTH'(1);
    // One combined flag so a complement fault on a correct count is one error.
    assign o_good     = (i_q == w_expected) && (i_qbar == ~i_q);
    assign o_wrap     = o_good && (i_prev == '1);

endmodule

// File: rtl/count_seq_checker.sv
// Monitors an up counter and its complement outputs, locks after LOCK_LEN
// consecutive good increments and then reports errors and wraps.
module count_seq_checker
    import count_chk_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LOCK_LEN = DEF_LOCK_LEN,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] qbar_in,
    input  logic             clear,
    output logic             locked,
    output logic             err,
    output logic             wrap,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] wrap_cnt,
    output logic [1:0]       state
);

    localparam int            MW       = $clog2(LOCK_LEN + 1);
    localparam logic [MW-1:0] LOCK_TGT = MW'(LOCK_LEN);

    state_t           r_state;
    logic             r_locked;
    logic             r_err;
    logic             r_wrap;
    logic [WIDTH-1:0] r_prev;
    logic [MW-1:0]    r_match;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_wrap_cnt;

    logic             w_good;
    logic             w_wrap;
    logic [MW-1:0]    w_match_inc;

    seq_cmp #(.WIDTH(WIDTH)) u_cmp (
        .i_prev (r_prev),
        .i_q    (q_in),
        .i_qbar (qbar_in),
        .o_good (w_good),
        .o_wrap (w_wrap)
    );

    assign w_match_inc = r_match + MW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_locked   <= 1'b0;
            r_err      <= 1'b0;
            r_wrap     <= 1'b0;
            r_prev     <= '0;
            r_match    <= '0;
            r_err_cnt  <= '0;
            r_wrap_cnt <= '0;
        end else if (clear) begin
            r_state    <= IDLE;
            r_locked   <= 1'b0;
            r_err      <= 1'b0;
            r_wrap     <= 1'b0;
            r_match    <= '0;
            r_err_cnt  <= '0;
            r_wrap_cnt <= '0;
        end else begin
            r_err  <= 1'b0;
            r_wrap <= 1'b0;
            if (en) begin
                r_prev <= q_in;
                case (r_state)
                    IDLE: begin
                        r_match  <= '0;
                        r_state  <= SYNC;
                        r_locked <= 1'b0;
                    end
                    SYNC: begin
                        if (w_good) begin
                            r_match <= w_match_inc;
                            if (w_match_inc >= LOCK_TGT) begin
                                r_state  <= LOCKED;
                                r_locked <= 1'b1;
                            end
                        end else begin
                            r_match <= '0;
                        end
                    end
                    LOCKED: begin
                        // Losing lock drops back to SYNC, not IDLE: prev is already valid.
                        if (!w_good) begin
                            r_err    <= 1'b1;
                            r_match  <= '0;
                            r_state  <= SYNC;
                            r_locked <= 1'b0;
                            if (r_err_cnt != '1) begin
                                r_err_cnt <= r_err_cnt + CNT_W'(1);
                            end
                        end else if (w_wrap) begin
                            r_wrap     <= 1'b1;
                            r_wrap_cnt <= r_wrap_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state  <= IDLE;
                        r_locked <= 1'b0;
                        r_match  <= '0;
                    end
                endcase
            end
        end
    end

    assign locked   = r_locked;
    assign err      = r_err;
    assign wrap     = r_wrap;
    assign err_cnt  = r_err_cnt;
    assign wrap_cnt = r_wrap_cnt;
    assign state    = r_state;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed self-checking bench for count_seq_checker with default parameters
// (WIDTH=4, LOCK_LEN=3, CNT_W=8).
module tb_count_seq_checker;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] q_in;
    logic [3:0] qbar_in;
    logic       clear;
    logic       locked;
    logic       err;
    logic       wrap;
    logic [7:0] err_cnt;
    logic [7:0] wrap_cnt;
    logic [1:0] state;

    int nCompared   = 0;
    int nMismatched = 0;

    count_seq_checker dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .q_in     (q_in),
        .qbar_in  (qbar_in),
        .clear    (clear),
        .locked   (locked),
        .err      (err),
        .wrap     (wrap),
        .err_cnt  (err_cnt),
        .wrap_cnt (wrap_cnt),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyRaw(input logic e, input logic [3:0] q, input logic [3:0] qb, input logic c);
        en      = e;
        q_in    = q;
        qbar_in = qb;
        clear   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic e, input logic [3:0] q, input logic c);
        applyRaw(e, q, ~q, c);
    endtask

    initial begin
        logic [3:0] cur;
        int         errs;

        rst_n   = 1'b0;
        en      = 1'b0;
        q_in    = 4'd0;
        qbar_in = 4'hF;
        clear   = 1'b0;
        #12;
        checkOutput("reset_state",    32'(state),    0);
        checkOutput("reset_locked",   32'(locked),   0);
        checkOutput("reset_err",      32'(err),      0);
        checkOutput("reset_wrap",     32'(wrap),     0);
        checkOutput("reset_err_cnt",  32'(err_cnt),  0);
        checkOutput("reset_wrap_cnt", 32'(wrap_cnt), 0);
        rst_n = 1'b1;

        // Free-running count from 0: capture, then three good samples lock.
        applyStimulus(1'b1, 4'd0, 1'b0);
        checkOutput("idle_to_sync", 32'(state), 1);
        applyStimulus(1'b1, 4'd1, 1'b0);
        applyStimulus(1'b1, 4'd2, 1'b0);
        checkOutput("sync_not_locked_yet", 32'(locked), 0);
        applyStimulus(1'b1, 4'd3, 1'b0);
        checkOutput("locked_after_3", 32'(locked), 1);
        checkOutput("state_locked",   32'(state),  2);
        checkOutput("no_err_lock",    32'(err),    0);

        for (int v = 4; v <= 14; v++) applyStimulus(1'b1, 4'(v), 1'b0);
        checkOutput("no_wrap_at_14", 32'(wrap), 0);
        applyStimulus(1'b1, 4'd15, 1'b0);
        checkOutput("no_wrap_at_15", 32'(wrap), 0);
        applyStimulus(1'b1, 4'd0, 1'b0);
        checkOutput("wrap_pulse",  32'(wrap),     1);
        checkOutput("wrap_cnt_1",  32'(wrap_cnt), 1);
        applyStimulus(1'b1, 4'd1, 1'b0);
        checkOutput("wrap_one_cycle", 32'(wrap),     0);
        checkOutput("wrap_cnt_hold",  32'(wrap_cnt), 1);

        // en=0 with a garbage value must not disturb prev or the FSM.
        applyStimulus(1'b0, 4'd9, 1'b0);
        checkOutput("freeze_state", 32'(state), 2);
        checkOutput("freeze_err",   32'(err),   0);
        applyStimulus(1'b1, 4'd2, 1'b0);
        checkOutput("freeze_prev_kept", 32'(locked), 1);
        checkOutput("freeze_no_err",    32'(err),    0);

        applyStimulus(1'b1, 4'd3, 1'b0);
        applyStimulus(1'b1, 4'd4, 1'b0);
        applyStimulus(1'b1, 4'd7, 1'b0);
        checkOutput("seq_err_pulse", 32'(err),     1);
        checkOutput("seq_err_cnt",   32'(err_cnt), 1);
        checkOutput("seq_err_state", 32'(state),   1);
        checkOutput("seq_err_unlock",32'(locked),  0);
        applyStimulus(1'b1, 4'd8, 1'b0);
        checkOutput("err_one_cycle", 32'(err),   0);
        applyStimulus(1'b1, 4'd9, 1'b0);
        checkOutput("relock_pending", 32'(state), 1);
        applyStimulus(1'b1, 4'd10, 1'b0);
        checkOutput("relocked", 32'(state),   2);
        checkOutput("err_cnt_held", 32'(err_cnt), 1);

        for (int v = 11; v <= 15; v++) applyStimulus(1'b1, 4'(v), 1'b0);
        applyStimulus(1'b1, 4'd0, 1'b0);
        checkOutput("wrap_cnt_2", 32'(wrap_cnt), 2);
        applyStimulus(1'b1, 4'd1, 1'b0);
        applyStimulus(1'b1, 4'd2, 1'b0);

        // Correct count, broken complement: a single error.
        applyRaw(1'b1, 4'b0011, 4'b0000, 1'b0);
        checkOutput("cmp_err_pulse", 32'(err),     1);
        checkOutput("cmp_err_cnt",   32'(err_cnt), 2);
        checkOutput("cmp_err_state", 32'(state),   1);
        applyStimulus(1'b1, 4'd4, 1'b0);
        applyStimulus(1'b1, 4'd9, 1'b0);
        checkOutput("sync_bad_no_err", 32'(err),     0);
        checkOutput("sync_bad_no_cnt", 32'(err_cnt), 2);
        checkOutput("sync_bad_stay",   32'(state),   1);

        // Drive errors to saturation: relock with 3 good samples, then skip one.
        cur  = 4'd9;
        errs = 2;
        for (int it = 0; it < 298; it++) begin
            for (int k = 0; k < 3; k++) begin
                cur = cur + 4'd1;
                applyStimulus(1'b1, cur, 1'b0);
            end
            if (it == 0) checkOutput("sat_relock", 32'(state), 2);
            cur = cur + 4'd2;
            applyStimulus(1'b1, cur, 1'b0);
            errs++;
            if (errs == 254) checkOutput("err_cnt_254", 32'(err_cnt), 254);
        end
        checkOutput("err_cnt_sat",    32'(err_cnt), 255);
        checkOutput("err_pulse_sat",  32'(err),     1);

        applyStimulus(1'b1, cur + 4'd1, 1'b1);
        checkOutput("clear_state",    32'(state),    0);
        checkOutput("clear_err_cnt",  32'(err_cnt),  0);
        checkOutput("clear_wrap_cnt", 32'(wrap_cnt), 0);
        checkOutput("clear_err",      32'(err),      0);
        checkOutput("clear_locked",   32'(locked),   0);

        applyStimulus(1'b1, 4'd12, 1'b0);
        applyStimulus(1'b1, 4'd13, 1'b0);
        applyStimulus(1'b1, 4'd14, 1'b0);
        applyStimulus(1'b1, 4'd15, 1'b0);
        checkOutput("post_clear_lock", 32'(locked), 1);
        applyStimulus(1'b1, 4'd0, 1'b0);
        applyStimulus(1'b1, 4'd1, 1'b0);
        applyStimulus(1'b1, 4'd5, 1'b0);
        applyStimulus(1'b1, 4'd6, 1'b0);
        applyStimulus(1'b1, 4'd7, 1'b0);
        applyStimulus(1'b1, 4'd8, 1'b0);
        checkOutput("pre_rst_locked",   32'(locked),   1);
        checkOutput("pre_rst_err_cnt",  32'(err_cnt),  1);
        checkOutput("pre_rst_wrap_cnt", 32'(wrap_cnt), 1);

        // Reset between edges must act immediately.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_state",    32'(state),    0);
        checkOutput("async_rst_locked",   32'(locked),   0);
        checkOutput("async_rst_err_cnt",  32'(err_cnt),  0);
        checkOutput("async_rst_wrap_cnt", 32'(wrap_cnt), 0);
        checkOutput("async_rst_err",      32'(err),      0);
        checkOutput("async_rst_wrap",     32'(wrap),     0);
        rst_n = 1'b1;

        applyStimulus(1'b1, 4'd9, 1'b0);
        checkOutput("post_rst_capture", 32'(state), 1);
        applyStimulus(1'b1, 4'd10, 1'b0);
        applyStimulus(1'b1, 4'd11, 1'b0);
        checkOutput("post_rst_not_yet", 32'(locked), 0);
        applyStimulus(1'b1, 4'd12, 1'b0);
        checkOutput("post_rst_relock",  32'(locked), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
